mem_arbiter: RTL
================

# mem_arbiter

Shares the single data-memory port between the core's memory-access stage and a host/loader requester. Issues at most one access per cycle and gives the core priority. A starvation counter forces a host grant after a bounded wait. Read data is routed back to the correct requester through a tag pipeline matched to the memory read latency.

## Interface
- `ADDR_SIZE`, default 10: memory word-index width. `m_addr = addr[ADDR_SIZE+1:2]`.
- `RD_LAT`, default 1: memory read latency in cycles. Legal values are 1 or 2.
- `MAX_WAIT`, default 4: maximum number of cycles the host may wait while the core is granted.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `c_req` in 1, `c_we` in 1, `c_addr` in 32, `c_wdata` in 32: core request.
- `c_gnt` out 1, `c_rvalid` out 1, `c_rdata` out 32: core response.
- `h_req` in 1, `h_we` in 1, `h_addr` in 32, `h_wdata` in 32: host request.
- `h_gnt` out 1, `h_rvalid` out 1, `h_rdata` out 32: host response.
- `m_en` out 1, `m_we` out 1, `m_addr` out ADDR_SIZE, `m_wdata` out 32: memory request.
- `m_rdata` in 32: memory read data, valid RD_LAT cycles after `m_en && !m_we`.
- `busy` out 1: a read is in flight in the tag pipeline.
- `c_cnt` out 32, `h_cnt` out 32, `conf_cnt` out 32: performance counters, present only with `MEM_ARB_PERF_EN`.

## Operation
- Requester handshake:
  - The requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`.
  - `gnt` is a one-cycle pulse; the access is issued to memory in that same cycle.
  - The requester may drop `req` or present a new request the cycle after `gnt`.
- Arbitration mode (`hpri` register), two states:
  - CORE_PRI (reset state): core wins when both request.
  - HOST_PRI: host wins when both request.
  - CORE_PRI to HOST_PRI when `wait_cnt == MAX_WAIT-1` and the host is still requesting and not granted.
  - HOST_PRI to CORE_PRI on the cycle `h_gnt` is asserted.
- `wait_cnt`:
  - Increments each cycle with `h_req && !h_gnt`, saturating at MAX_WAIT.
  - Clears on `h_gnt` or when `!h_req`.
- Single requester: it is granted the same cycle, regardless of mode.
- Memory request:
  - `m_en` = OR of the grants.
  - `m_we`, `m_addr`, `m_wdata` are muxed from the winner.
  - When `m_en = 0`, all `m_*` outputs drive 0.
- Tag pipeline:
  - Depth RD_LAT, entries `{valid, port}`.
  - An entry is pushed on every granted read; writes push `valid = 0`.
  - At the head: when `valid = 1`, pulse `rvalid` for the tagged port.
  - `c_rdata` and `h_rdata` are `m_rdata` when the matching `rvalid` is high, otherwise 0.
- Back-to-back reads, from either port, are issued every cycle. Responses return in issue order.
- Write immediately followed by a read of the same address: ordering follows memory-port order; no forwarding here.
- `busy` = OR of the tag-pipeline valid bits.

## Timing
- `gnt` and `m_*` are combinational from `req` and the registered `hpri`; the req-to-gnt path lies within one cycle.
- Read latency from `gnt` to `rvalid` is RD_LAT cycles. Throughput is one access per cycle.
- Reset values:
  - All registered state: `hpri`=CORE_PRI, `wait_cnt`=0, tags=0, counters=0.
  - With no requests active, every output reads 0.
- Reset mid-operation:
  - In-flight tags are discarded immediately.
  - No `rvalid` is produced after `rst_n` deasserts for reads issued before reset.
- Starvation bound: the host waits at most MAX_WAIT cycles while `c_req` is held continuously.

## Configuration
- `MEM_ARB_PERF_EN` defined:
  - `c_cnt` counts core grants; `h_cnt` counts host grants.
  - `conf_cnt` counts cycles with `c_req && h_req`.
  - All three are 32-bit, wrap modulo 2^32 and reset to 0.
- `MEM_ARB_PERF_EN` undefined: the three counter ports and their registers are absent.

## Structure
- Package `mem_arb_pkg`:
  - `arb_port_e` enum: ARB_CORE=0, ARB_HOST=1.
  - `arb_mode_e` enum: CORE_PRI, HOST_PRI.
  - `mem_req_t` packed struct: `{we, addr[31:0], wdata[31:0]}`.
  - `rd_tag_t` packed struct: `{valid, port}`.
- Sub-module `mem_arb_tagpipe`: the RD_LAT-deep shift register of `rd_tag_t` with asynchronous clear. Everything else stays in `mem_arbiter`.

## Test plan
- Core-only reads at addresses 0x0, 0x4, 0x8 on consecutive cycles:
  - `c_gnt` is high 3 cycles.
  - `m_addr` = 0, 1, 2.
  - `c_rvalid` pulses RD_LAT cycles later with the preloaded data; `h_rvalid` stays 0.
- Both request continuously with MAX_WAIT=4:
  - Core is granted 4 cycles, then host 1 cycle, then core resumes.
  - The pattern repeats; the host never waits more than 4 cycles.
- Host writes 0xDEADBEEF to 0x40, then the core reads 0x40 the next cycle:
  - `m_we` sequence 1, 0.
  - `c_rdata` = 0xDEADBEEF with `c_rvalid`.
- Interleaved reads (core at 0x10, host at 0x20, core at 0x30) with RD_LAT=2:
  - `rvalid` pulses arrive at the correct ports, in order.
  - Each returns its own data.
- `rst_n` asserted low the cycle after a granted read:
  - No `rvalid` appears afterwards.
  - `busy` = 0, `hpri` = CORE_PRI, all outputs are 0 during reset.
- `MEM_ARB_PERF_EN`: 10 cycles of dual requests followed by 3 host-only grants:
  - `conf_cnt` = 10.
  - `c_cnt` + `h_cnt` = 13.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: requester ids, arbitration
// modes, the request bundle and the read-tag entry carried through the
// tag pipeline.
package mem_arb_pkg;

  // Which requester an access belongs to.
  typedef enum logic {
    ARB_CORE = 1'b0,
    ARB_HOST = 1'b1
  } arb_port_e;

  // Which requester wins when both ask in the same cycle.
  typedef enum logic {
    CORE_PRI = 1'b0,
    HOST_PRI = 1'b1
  } arb_mode_e;

  // One requester's access, as presented on its request port.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // One read-tag entry: whether a read is in flight and who issued it.
  typedef struct packed {
    logic      valid;
    arb_port_e port;
  } rd_tag_t;

  // Empty tag slot, used for writes, idle cycles and reset.
  localparam rd_tag_t TAG_IDLE = '{valid: 1'b0, port: ARB_CORE};

  // Picks the winning port. A lone requester always wins regardless of the
  // mode; the mode only matters on contention. With nobody requesting the
  // result is ARB_CORE, which the caller masks with the request lines.
  function automatic arb_port_e pick_winner(input logic      core_req,
                                            input logic      host_req,
                                            input arb_mode_e mode);
    arb_port_e win;
    if (core_req && host_req) begin
      win = (mode == HOST_PRI) ? ARB_HOST : ARB_CORE;
    end else if (host_req) begin
      win = ARB_HOST;
    end else begin
      win = ARB_CORE;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_arb_tagpipe.sv
// Read-tag shift register for the memory arbiter. One entry is pushed per
// cycle; the entry leaving the last stage lines up with the memory's read
// data, so its owner can be told that the data on m_rdata is theirs.
// The asynchronous clear drops every in-flight tag so that no response is
// delivered for reads issued before a reset.
module mem_arb_tagpipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_valid,
  input  logic push_port,
  output logic head_valid,
  output logic head_port,
  output logic busy
);

  rd_tag_t push_tag;
  rd_tag_t stage [DEPTH];

  // Bundle the incoming tag bits into a tag entry.
  always_comb begin
    push_tag       = TAG_IDLE;
    push_tag.valid = push_valid;
    push_tag.port  = arb_port_e'(push_port);
  end

  // Shift the tags one stage per cycle; reset throws away everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= TAG_IDLE;
      end
    end else begin
      stage[0] <= push_tag;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // Present the oldest entry, whose read data is on the memory bus this cycle.
  always_comb begin
    head_valid = stage[DEPTH-1].valid;
    head_port  = logic'(stage[DEPTH-1].port);
  end

  // Report whether any read is still travelling through the pipeline.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy = busy | stage[i].valid;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Data-memory arbiter between the core's memory stage and a host/loader.
// One access per cycle, core preferred, with a starvation counter that
// hands the host priority after it has waited MAX_WAIT cycles. Read data
// is steered back to its issuer through a tag pipeline as deep as the
// memory read latency (RD_LAT must be 1 or 2).
// Optional feature: define MEM_ARB_PERF_EN to add the c_cnt / h_cnt /
// conf_cnt performance counters and their ports.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_SIZE = 10,
  parameter int RD_LAT    = 1,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 c_req,
  input  logic                 c_we,
  input  logic [31:0]          c_addr,
  input  logic [31:0]          c_wdata,
  output logic                 c_gnt,
  output logic                 c_rvalid,
  output logic [31:0]          c_rdata,

  input  logic                 h_req,
  input  logic                 h_we,
  input  logic [31:0]          h_addr,
  input  logic [31:0]          h_wdata,
  output logic                 h_gnt,
  output logic                 h_rvalid,
  output logic [31:0]          h_rdata,

  output logic                 m_en,
  output logic                 m_we,
  output logic [ADDR_SIZE-1:0] m_addr,
  output logic [31:0]          m_wdata,
  input  logic [31:0]          m_rdata,

  output logic                 busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]          c_cnt,
  output logic [31:0]          h_cnt,
  output logic [31:0]          conf_cnt
`endif
);

  // The wait counter must be able to hold MAX_WAIT itself, since it saturates there.
  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  arb_mode_e         hpri;
  arb_mode_e         hpri_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;

  arb_port_e         winner;
  mem_req_t          core_req;
  mem_req_t          host_req;
  mem_req_t          win_req;

  logic              push_valid;
  logic              push_port;
  logic              head_valid;
  logic              head_port;
  logic              tags_busy;

  logic              unused_addr_bits;

  // Decide who gets the memory port this cycle from the live requests and the registered mode.
  always_comb begin
    winner = pick_winner(c_req, h_req, hpri);
    c_gnt  = c_req && (winner == ARB_CORE);
    h_gnt  = h_req && (winner == ARB_HOST);
  end

  // Bundle each requester's signals and select the winner's access.
  always_comb begin
    core_req = '{we: c_we, addr: c_addr, wdata: c_wdata};
    host_req = '{we: h_we, addr: h_addr, wdata: h_wdata};
    win_req  = (winner == ARB_HOST) ? host_req : core_req;
  end

  // Drive the memory port; everything is held at zero when no access is issued.
  always_comb begin
    m_en    = c_gnt | h_gnt;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (m_en) begin
      m_we    = win_req.we;
      m_addr  = win_req.addr[ADDR_SIZE+1:2];
      m_wdata = win_req.wdata;
    end
  end

  // Byte-offset bits and bits above the memory size are not part of the word index.
  assign unused_addr_bits = ^{win_req.addr[31:ADDR_SIZE+2], win_req.addr[1:0]};

  // Work out the next arbitration mode and how long the host has been kept waiting.
  always_comb begin
    hpri_next = hpri;
    wait_next = wait_cnt;

    case (hpri)
      CORE_PRI: begin
        if (h_req && !h_gnt && (wait_cnt == WAIT_LAST)) begin
          hpri_next = HOST_PRI;
        end
      end
      HOST_PRI: begin
        if (h_gnt) begin
          hpri_next = CORE_PRI;
        end
      end
      default: hpri_next = CORE_PRI;
    endcase

    if (!h_req || h_gnt) begin
      wait_next = '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_next = wait_cnt + WAIT_ONE;
    end
  end

  // Hold the arbitration mode and the host wait count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpri     <= CORE_PRI;
      wait_cnt <= '0;
    end else begin
      hpri     <= hpri_next;
      wait_cnt <= wait_next;
    end
  end

  // Tag every issued access; only reads carry a valid tag, writes push an empty slot.
  always_comb begin
    push_valid = m_en && !m_we;
    push_port  = h_gnt;
  end

  mem_arb_tagpipe #(
    .DEPTH (RD_LAT)
  ) u_tagpipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push_valid),
    .push_port  (push_port),
    .head_valid (head_valid),
    .head_port  (head_port),
    .busy       (tags_busy)
  );

  // Steer the returning read data to whichever port issued the read.
  always_comb begin
    c_rvalid = 1'b0;
    h_rvalid = 1'b0;
    c_rdata  = '0;
    h_rdata  = '0;
    if (head_valid) begin
      if (arb_port_e'(head_port) == ARB_HOST) begin
        h_rvalid = 1'b1;
        h_rdata  = m_rdata;
      end else begin
        c_rvalid = 1'b1;
        c_rdata  = m_rdata;
      end
    end
  end

  assign busy = tags_busy;

`ifdef MEM_ARB_PERF_EN
  // Count grants per port and cycles in which both ports competed; all wrap at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_cnt    <= '0;
      h_cnt    <= '0;
      conf_cnt <= '0;
    end else begin
      if (c_gnt) begin
        c_cnt <= c_cnt + 32'd1;
      end
      if (h_gnt) begin
        h_cnt <= h_cnt + 32'd1;
      end
      if (c_req && h_req) begin
        conf_cnt <= conf_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
